// File: rtl/writeback_stage_if.sv
// Write-back stage bus: upstream instruction handshake, memory load return
// and register-file write port, with status outputs.
interface writeback_stage_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
);
  logic              valid_i;
  logic              ready_o;
  logic [DATA_W-1:0] pc_plus4_i;
  logic [DATA_W-1:0] alu_result_i;
  logic [4:0]        rc_i;
  logic              werf_i;
  logic [1:0]        wdsel_i;
  logic [DATA_W-1:0] mem_rdata_i;
  logic              mem_rvalid_i;
  logic [4:0]        rf_rc_o;
  logic              rf_werf_o;
  logic [DATA_W-1:0] rf_wd_o;
  logic [CNT_W-1:0]  retire_count_o;
  logic              err_o;

  modport master (
    output valid_i, pc_plus4_i, alu_result_i, rc_i, werf_i, wdsel_i,
           mem_rdata_i, mem_rvalid_i,
    input  ready_o, rf_rc_o, rf_werf_o, rf_wd_o, retire_count_o, err_o
  );

  modport slave (
    input  valid_i, pc_plus4_i, alu_result_i, rc_i, werf_i, wdsel_i,
           mem_rdata_i, mem_rvalid_i,
    output ready_o, rf_rc_o, rf_werf_o, rf_wd_o, retire_count_o, err_o
  );
endinterface

// File: rtl/writeback_stage.sv
// Final pipeline stage: selects write-back data, stalls loads until memory
// data returns (with timeout) and drives a one-cycle register-file write.
module writeback_stage #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned TO_W        = 4,
  parameter int unsigned CNT_W       = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  writeback_stage_if.slave   bus
);
  localparam logic [4:0] R31 = 5'd31;

  typedef enum logic [1:0] {IDLE, WAIT_MEM, WRITE} state_t;

  state_t            state;
  logic [4:0]        pend_rc;
  logic [TO_W-1:0]   to_cnt;
  logic [TO_W-1:0]   to_next;
  logic              accept;
  logic              is_load;
  logic [DATA_W-1:0] sel_data;

  assign bus.ready_o = (state != WAIT_MEM);
  assign accept      = bus.valid_i & bus.ready_o;
  assign is_load     = bus.werf_i & (bus.wdsel_i == 2'd2);
  // wdsel 1 and the reserved encoding 3 both select the ALU result
  assign sel_data    = (bus.wdsel_i == 2'd0) ? bus.pc_plus4_i : bus.alu_result_i;
  assign to_next     = to_cnt + TO_W'(1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state              <= IDLE;
      pend_rc            <= '0;
      to_cnt             <= '0;
      bus.rf_rc_o        <= '0;
      bus.rf_werf_o      <= 1'b0;
      bus.rf_wd_o        <= '0;
      bus.retire_count_o <= '0;
      bus.err_o          <= 1'b0;
    end else begin
      bus.rf_werf_o <= 1'b0;
      case (state)
        IDLE, WRITE: begin
          if (state == WRITE) bus.retire_count_o <= bus.retire_count_o + CNT_W'(1);
          if (accept) begin
            if (is_load) begin
              state   <= WAIT_MEM;
              pend_rc <= bus.rc_i;
              to_cnt  <= '0;
            end else begin
              state <= WRITE;
              // rc/wd only move when a write really happens, so they hold otherwise
              if (bus.werf_i && (bus.rc_i != R31)) begin
                bus.rf_werf_o <= 1'b1;
                bus.rf_rc_o   <= bus.rc_i;
                bus.rf_wd_o   <= sel_data;
              end
            end
          end else begin
            state <= IDLE;
          end
        end
        WAIT_MEM: begin
          // returning data takes priority over a simultaneous timeout
          if (bus.mem_rvalid_i) begin
            state <= WRITE;
            if (pend_rc != R31) begin
              bus.rf_werf_o <= 1'b1;
              bus.rf_rc_o   <= pend_rc;
              bus.rf_wd_o   <= bus.mem_rdata_i;
            end
          end else if (to_next == TO_W'(MEM_TIMEOUT)) begin
            state     <= WRITE;
            to_cnt    <= to_next;
            bus.err_o <= 1'b1;
          end else begin
            to_cnt <= to_next;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_writeback_stage.sv
// Directed self-checking bench for writeback_stage: reset, ALU/JMP/load
// paths, R31 suppression, load timeout and retire-counter wrap.
module tb_writeback_stage;
  logic clk;
  logic rst;
  int   n_total;
  int   n_pass;

  writeback_stage_if #(.DATA_W(32), .CNT_W(16)) bus1 ();
  writeback_stage_if #(.DATA_W(32), .CNT_W(4))  bus2 ();

  writeback_stage #(.CNT_W(16)) dut (.clk_i(clk), .rst_i(rst), .bus(bus1.slave));
  writeback_stage #(.CNT_W(4))  dut_w (.clk_i(clk), .rst_i(rst), .bus(bus2.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive1(input logic v, input logic w, input logic [1:0] sel,
                        input logic [4:0] rc, input logic [31:0] alu, input logic [31:0] pc);
    bus1.valid_i      = v;
    bus1.werf_i       = w;
    bus1.wdsel_i      = sel;
    bus1.rc_i         = rc;
    bus1.alu_result_i = alu;
    bus1.pc_plus4_i   = pc;
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    rst = 1'b1;
    drive1(1'b0, 1'b0, 2'd0, 5'd0, 32'd0, 32'd0);
    bus1.mem_rdata_i = '0;  bus1.mem_rvalid_i = 1'b0;
    bus2.valid_i = 1'b0; bus2.werf_i = 1'b0; bus2.wdsel_i = 2'd0; bus2.rc_i = '0;
    bus2.alu_result_i = '0; bus2.pc_plus4_i = '0; bus2.mem_rdata_i = '0; bus2.mem_rvalid_i = 1'b0;
    #12;
    check("rst_ready", 64'(bus1.ready_o), 64'd1);
    check("rst_werf",  64'(bus1.rf_werf_o), 64'd0);
    check("rst_wd",    64'(bus1.rf_wd_o), 64'd0);
    check("rst_count", 64'(bus1.retire_count_o), 64'd0);
    check("rst_err",   64'(bus1.err_o), 64'd0);
    rst = 1'b0;

    // one ALU op, then reset while a load waits
    drive1(1'b1, 1'b1, 2'd1, 5'd2, 32'h11, 32'h0);
    step();
    bus1.valid_i = 1'b0;
    step();
    check("pre_count", 64'(bus1.retire_count_o), 64'd1);
    drive1(1'b1, 1'b1, 2'd2, 5'd7, 32'h0, 32'h0);
    step();
    bus1.valid_i = 1'b0;
    check("load_stall", 64'(bus1.ready_o), 64'd0);
    rst = 1'b1;
    #1;
    check("midrst_ready", 64'(bus1.ready_o), 64'd1);
    check("midrst_werf",  64'(bus1.rf_werf_o), 64'd0);
    check("midrst_count", 64'(bus1.retire_count_o), 64'd0);
    rst = 1'b0;
    step();

    // back-to-back ALU ops
    for (int i = 1; i <= 4; i++) begin
      drive1(1'b1, 1'b1, 2'd1, 5'(i), 32'hDEADC0DE + 32'(i), 32'h0);
      step();
      check("b2b_werf", 64'(bus1.rf_werf_o), 64'd1);
      check("b2b_rc",   64'(bus1.rf_rc_o), 64'(i));
      check("b2b_wd",   64'(bus1.rf_wd_o), 64'(32'hDEADC0DE + 32'(i)));
    end
    bus1.valid_i = 1'b0;
    step();
    check("b2b_count", 64'(bus1.retire_count_o), 64'd4);
    check("b2b_idle_werf", 64'(bus1.rf_werf_o), 64'd0);
    check("b2b_hold_wd", 64'(bus1.rf_wd_o), 64'h00000000DEADC0E2);

    // stray mem_rvalid in IDLE is ignored
    bus1.mem_rvalid_i = 1'b1; bus1.mem_rdata_i = 32'h123;
    step();
    bus1.mem_rvalid_i = 1'b0;
    check("stray_werf", 64'(bus1.rf_werf_o), 64'd0);
    check("stray_wd",   64'(bus1.rf_wd_o), 64'h00000000DEADC0E2);

    // load with data returning three cycles later
    drive1(1'b1, 1'b1, 2'd2, 5'd5, 32'h0, 32'h0);
    step();
    bus1.valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("ld_ready_low", 64'(bus1.ready_o), 64'd0);
      check("ld_no_werf", 64'(bus1.rf_werf_o), 64'd0);
      if (i < 2) step();
    end
    bus1.mem_rvalid_i = 1'b1; bus1.mem_rdata_i = 32'hCAFEBABE;
    step();
    bus1.mem_rvalid_i = 1'b0;
    check("ld_ready_back", 64'(bus1.ready_o), 64'd1);
    check("ld_werf", 64'(bus1.rf_werf_o), 64'd1);
    check("ld_rc",   64'(bus1.rf_rc_o), 64'd5);
    check("ld_wd",   64'(bus1.rf_wd_o), 64'h00000000CAFEBABE);
    step();
    check("ld_werf_drop", 64'(bus1.rf_werf_o), 64'd0);
    check("ld_count", 64'(bus1.retire_count_o), 64'd5);

    // JMP link to R31: retires but never writes
    drive1(1'b1, 1'b1, 2'd0, 5'd31, 32'h0, 32'h00000104);
    step();
    bus1.valid_i = 1'b0;
    check("r31_werf", 64'(bus1.rf_werf_o), 64'd0);
    check("r31_rc_hold", 64'(bus1.rf_rc_o), 64'd5);
    step();
    check("r31_count", 64'(bus1.retire_count_o), 64'd6);

    // werf=0 with wdsel=2 goes straight through without waiting
    drive1(1'b1, 1'b0, 2'd2, 5'd9, 32'h0, 32'h0);
    step();
    bus1.valid_i = 1'b0;
    check("nowr_ready", 64'(bus1.ready_o), 64'd1);
    check("nowr_werf", 64'(bus1.rf_werf_o), 64'd0);
    step();
    check("nowr_count", 64'(bus1.retire_count_o), 64'd7);

    // reserved wdsel=3 selects ALU; PC+4 selectable via wdsel=0
    drive1(1'b1, 1'b1, 2'd3, 5'd10, 32'h0000A5A5, 32'h00000200);
    step();
    drive1(1'b1, 1'b1, 2'd0, 5'd14, 32'h0000A5A5, 32'h00000204);
    check("sel3_wd", 64'(bus1.rf_wd_o), 64'h000000000000A5A5);
    check("sel3_rc", 64'(bus1.rf_rc_o), 64'd10);
    step();
    bus1.valid_i = 1'b0;
    check("pc4_wd", 64'(bus1.rf_wd_o), 64'h0000000000000204);
    step();
    check("sel_count", 64'(bus1.retire_count_o), 64'd9);

    // data arriving on the timeout edge wins, no error
    drive1(1'b1, 1'b1, 2'd2, 5'd13, 32'h0, 32'h0);
    step();
    bus1.valid_i = 1'b0;
    repeat (14) step();
    check("race_ready", 64'(bus1.ready_o), 64'd0);
    bus1.mem_rvalid_i = 1'b1; bus1.mem_rdata_i = 32'h000055AA;
    step();
    bus1.mem_rvalid_i = 1'b0;
    check("race_werf", 64'(bus1.rf_werf_o), 64'd1);
    check("race_wd",   64'(bus1.rf_wd_o), 64'h00000000000055AA);
    check("race_err",  64'(bus1.err_o), 64'd0);
    step();

    // load timeout: 15 WAIT_MEM cycles, error, no write
    drive1(1'b1, 1'b1, 2'd2, 5'd11, 32'h0, 32'h0);
    step();
    bus1.valid_i = 1'b0;
    repeat (14) step();
    check("to_ready_still_low", 64'(bus1.ready_o), 64'd0);
    check("to_err_not_yet", 64'(bus1.err_o), 64'd0);
    step();
    check("to_err", 64'(bus1.err_o), 64'd1);
    check("to_werf", 64'(bus1.rf_werf_o), 64'd0);
    check("to_ready", 64'(bus1.ready_o), 64'd1);
    step();
    check("to_count", 64'(bus1.retire_count_o), 64'd11);
    drive1(1'b1, 1'b1, 2'd1, 5'd12, 32'h77, 32'h0);
    step();
    bus1.valid_i = 1'b0;
    check("post_to_werf", 64'(bus1.rf_werf_o), 64'd1);
    check("post_to_wd",   64'(bus1.rf_wd_o), 64'h77);
    step();
    check("post_to_count", 64'(bus1.retire_count_o), 64'd12);
    check("err_sticky", 64'(bus1.err_o), 64'd1);

    // 4-bit retire counter wraps after 17 ops
    bus2.valid_i = 1'b1; bus2.werf_i = 1'b1; bus2.wdsel_i = 2'd1; bus2.rc_i = 5'd3;
    repeat (17) step();
    bus2.valid_i = 1'b0;
    step();
    check("wrap_count", 64'(bus2.retire_count_o), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
